hova_trace_monitor: RTL

Parametrised execution monitor for the Hova core on the TT harness. It tracks the core's instruction stage and captures the shared output bus into N per-stage channel registers. A branch-trace FIFO records non-sequential values of one designated channel (the PC), and the block flags a jump-to-self halt. It feeds the board display mux and a debug readout, replacing ad-hoc per-design stage/capture logic.

---
 rtl/hova_trace_monitor_pkg.sv | 19 +
 rtl/hova_trace_monitor_if.sv | 36 +++
 rtl/hova_trace_monitor_trace_fifo.sv | 69 ++++++
 rtl/hova_trace_monitor.sv | 116 +++++++++++
 4 files changed

// File: rtl/hova_trace_monitor_pkg.sv
// Shared constants and helpers for the Hova execution monitor.
package hova_mon_pkg;

  localparam int unsigned STAGE_W      = 3;
  localparam int unsigned DEF_CHANNELS = 2;

  // Channel 0 captures at stage 3 (PC), channel 1 at stage 4.
  localparam logic [DEF_CHANNELS*STAGE_W-1:0] DEF_CAP_STAGES = {3'd4, 3'd3};

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/hova_trace_monitor_if.sv
// Core-side bus, display select and trace readout of the execution monitor.
interface hova_mon_if
  import hova_mon_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CHANNELS = 2
);

  logic                         ena;
  logic [DATA_W-1:0]            bus_in;
  logic [1:0]                   sel;
  logic                         trace_rd;
  logic [STAGE_W-1:0]           stage_out;
  logic [DATA_W-1:0]            disp_out;
  logic [CHANNELS*DATA_W-1:0]   chan_flat;
  logic [CHANNELS-1:0]          cap_valid;
  logic [15:0]                  loop_count;
  logic [DATA_W-1:0]            trace_data;
  logic                         trace_empty;
  logic                         trace_full;
  logic                         trace_overflow;
  logic                         halted;

  modport master (
    output ena, bus_in, sel, trace_rd,
    input  stage_out, disp_out, chan_flat, cap_valid, loop_count,
           trace_data, trace_empty, trace_full, trace_overflow, halted
  );

  modport slave (
    input  ena, bus_in, sel, trace_rd,
    output stage_out, disp_out, chan_flat, cap_valid, loop_count,
           trace_data, trace_empty, trace_full, trace_overflow, halted
  );

endinterface

// File: rtl/hova_trace_monitor_trace_fifo.sv
// Show-ahead branch-trace FIFO with registered status and sticky overflow.
module trace_fifo
  import hova_mon_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_q, wr_d, rd_q, rd_d, level_after_pop;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              empty_q, empty_d, full_q, full_d, ovf_q, ovf_d;
  logic              push_acc, pop_acc;

  // A pop at full frees the slot the simultaneous push lands in.
  always_comb begin
    pop_acc         = pop && !empty_q;
    push_acc        = push && (!full_q || pop);
    wr_d            = wr_q + (AW+1)'(push_acc);
    rd_d            = rd_q + (AW+1)'(pop_acc);
    level_after_pop = wr_q - rd_d;
    empty_d         = (wr_d == rd_d);
    full_d          = (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
    ovf_d           = ovf_q || (push && !push_acc);
    dout_d          = dout_q;
    if (push_acc && (level_after_pop == '0)) dout_d = din;
    else if (level_after_pop != '0)          dout_d = mem_q[rd_d[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      dout_q  <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      dout_q  <= dout_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dout     = dout_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/hova_trace_monitor.sv
// Hova execution monitor: stage tracking, per-stage bus capture, branch trace and halt detect.
module hova_trace_monitor
  import hova_mon_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned CHANNELS   = 2,
  parameter logic [CHANNELS*STAGE_W-1:0] CAP_STAGES = (CHANNELS*STAGE_W)'(DEF_CAP_STAGES),
  parameter int unsigned TRACE_CH   = 0,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned HALT_COUNT = 4
) (
  input  logic     tt_clk,
  input  logic     tt_rst_n,
  hova_mon_if.slave mon
);

  localparam int unsigned HCW = clog2(HALT_COUNT) + 1;
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
  localparam logic [HCW-1:0]     HALT_AT    = HCW'(HALT_COUNT - 1);

  logic [STAGE_W-1:0]               stage_q, stage_d;
  logic [15:0]                      loop_q, loop_d;
  logic [CHANNELS-1:0]              cap_hit, cap_valid_q;
  logic [CHANNELS-1:0][DATA_W-1:0]  chan_q, chan_d;
  logic [HCW-1:0]                   halt_cnt_q, halt_cnt_d;
  logic                             first_q, first_d, halted_q, halted_d;
  logic                             push_c;
  logic [DATA_W-1:0]                prev_c, disp_c;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_cap
    assign cap_hit[k] = mon.ena && (stage_q == CAP_STAGES[k*STAGE_W +: STAGE_W]);
    assign chan_d[k]  = cap_hit[k] ? mon.bus_in : chan_q[k];
  end

  // The trace channel register only changes on its own captures, so it is the previous PC.
  assign prev_c = chan_q[TRACE_CH];

  always_comb begin
    stage_d    = stage_q;
    loop_d     = loop_q;
    first_d    = first_q;
    halt_cnt_d = halt_cnt_q;
    halted_d   = halted_q;
    push_c     = 1'b0;
    if (mon.ena) begin
      if (stage_q == LAST_STAGE) begin
        stage_d = '0;
        loop_d  = loop_q + 16'd1;
      end else begin
        stage_d = stage_q + STAGE_W'(1);
      end
    end
    if (cap_hit[TRACE_CH]) begin
      first_d = 1'b0;
      push_c  = first_q || (mon.bus_in != prev_c + DATA_W'(1));
      if (!first_q && (mon.bus_in == prev_c)) begin
        if (halt_cnt_q != HALT_AT) halt_cnt_d = halt_cnt_q + HCW'(1);
      end else begin
        halt_cnt_d = '0;
      end
      if (halt_cnt_d == HALT_AT) halted_d = 1'b1;
    end
  end

  always_ff @(posedge tt_clk) begin
    if (!tt_rst_n) begin
      stage_q     <= '0;
      loop_q      <= '0;
      chan_q      <= '0;
      cap_valid_q <= '0;
      halt_cnt_q  <= '0;
      first_q     <= 1'b1;
      halted_q    <= 1'b0;
    end else begin
      stage_q     <= stage_d;
      loop_q      <= loop_d;
      chan_q      <= chan_d;
      cap_valid_q <= cap_hit;
      halt_cnt_q  <= halt_cnt_d;
      first_q     <= first_d;
      halted_q    <= halted_d;
    end
  end

  // Out-of-range selects fall back to channel 0.
  always_comb begin
    disp_c = chan_q[0];
    for (int k = 0; k < CHANNELS; k++) begin
      if (mon.sel == 2'(k)) disp_c = chan_q[k];
    end
  end

  trace_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_trace_fifo (
    .clk      (tt_clk),
    .rst_n    (tt_rst_n),
    .push     (push_c),
    .pop      (mon.trace_rd),
    .din      (mon.bus_in),
    .dout     (mon.trace_data),
    .empty    (mon.trace_empty),
    .full     (mon.trace_full),
    .overflow (mon.trace_overflow)
  );

  assign mon.stage_out  = stage_q;
  assign mon.disp_out   = disp_c;
  assign mon.chan_flat  = chan_q;
  assign mon.cap_valid  = cap_valid_q;
  assign mon.loop_count = loop_q;
  assign mon.halted     = halted_q;

endmodule
